// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI command engine.
// The optional serial CRC7 generator is enabled with SD_CRC7_EN.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    POLL,
    TRAIL
  } sd_state_e;

  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;
  localparam logic [7:0] SD_CRC_CMD0  = 8'h95;
  localparam logic [7:0] SD_CRC_CMD8  = 8'h87;
  localparam logic [7:0] SD_CRC_NONE  = 8'h01;

  // Last command byte when no CRC generator is built in.
  function automatic logic [7:0] sd_fixed_crc(
    input logic [5:0] idx
  );
    logic [7:0] b;
    b = SD_CRC_NONE;
    if (idx == 6'd0)
      b = SD_CRC_CMD0;
    else if (idx == 6'd8)
      b = SD_CRC_CMD8;
    return b;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), initial value zero.
// Instantiated by sd_cmd_engine only when SD_CRC7_EN is defined.
module sd_crc7 (
  input  logic       CLKin,
  input  logic       Reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  always_ff @(posedge CLKin or posedge Reset) begin
    if (Reset)
      crc <= 7'd0;
    else if (clr)
      crc <= 7'd0;
    else if (en)
      crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD SPI command engine: frames a 6-byte command, polls for R1, trails 8 clocks.
// Define SD_CRC7_EN to compute CRC7 on the fly instead of fixed CRC bytes.
import sd_pkg::*;

module sd_cmd_engine #(
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        CLKin,
  input  logic        Reset,
  input  logic        Start,
  input  logic [5:0]  CmdIndex,
  input  logic [31:0] CmdArg,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  Resp,
  output logic        Timeout,
  output logic        SD_SCLK,
  output logic        SD_MOSI,
  input  logic        SD_MISO,
  output logic        SD_CS_n
);

  localparam logic [7:0] LAST_POLL = 8'(RESP_TIMEOUT - 1);

  sd_state_e   state_q;
  sd_state_e   state_d;
  logic        accept;
  logic        ph_q;
  logic [5:0]  bit_q;
  logic [7:0]  byte_q;
  logic [39:0] sh_q;
  logic [7:0]  rx_q;
  logic        tmo_q;
  logic [7:0]  tail;
  logic        byte_end;

`ifdef SD_CRC7_EN
  logic [6:0] crc;

  sd_crc7 u_crc (
    .CLKin (CLKin),
    .Reset (Reset),
    .clr   (accept),
    .en    (state_q == SEND && ph_q && bit_q < 6'd40),
    .din   (sh_q[39]),
    .crc   (crc)
  );

  assign tail = {crc, 1'b1};
`else
  logic [7:0] tail_q;

  always_ff @(posedge CLKin or posedge Reset) begin
    if (Reset)
      tail_q <= SD_CRC_NONE;
    else if (accept)
      tail_q <= sd_fixed_crc(CmdIndex);
  end

  assign tail = tail_q;
`endif

  assign byte_end = ph_q && (bit_q[2:0] == 3'd7);

  always_ff @(posedge CLKin or posedge Reset) begin
    if (Reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ph_q && bit_q == 6'd47)
          state_d = POLL;
      end
      POLL: begin
        // rx_q[6] becomes bit7 of the byte completing on this edge
        if (byte_end && (!rx_q[6] || byte_q == LAST_POLL))
          state_d = TRAIL;
      end
      TRAIL: begin
        if (byte_end)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKin or posedge Reset) begin
    if (Reset) begin
      ph_q    <= 1'b0;
      bit_q   <= 6'd0;
      byte_q  <= 8'd0;
      sh_q    <= '1;
      rx_q    <= SD_IDLE_BYTE;
      tmo_q   <= 1'b0;
      Done    <= 1'b0;
      Resp    <= SD_IDLE_BYTE;
      Timeout <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        ph_q   <= 1'b0;
        bit_q  <= 6'd0;
        byte_q <= 8'd0;
        sh_q   <= {2'b01, CmdIndex, CmdArg};
        rx_q   <= SD_IDLE_BYTE;
        tmo_q  <= 1'b0;
      end else if (state_q != IDLE) begin
        ph_q <= ~ph_q;
        if (ph_q)
          bit_q <= bit_q + 6'd1;
        if (state_q == SEND && ph_q)
          sh_q <= {sh_q[38:0], 1'b1};
        if (state_q == POLL && ph_q) begin
          rx_q <= {rx_q[6:0], SD_MISO};
          if (bit_q[2:0] == 3'd7)
            byte_q <= byte_q + 8'd1;
        end
        if (state_q == POLL && state_d == TRAIL)
          tmo_q <= rx_q[6];
        if (state_q == TRAIL && state_d == IDLE) begin
          Done    <= 1'b1;
          Resp    <= tmo_q ? SD_IDLE_BYTE : rx_q;
          Timeout <= tmo_q;
        end
      end
    end
  end

  assign Busy    = (state_q != IDLE);
  assign SD_SCLK = (state_q != IDLE) && ph_q;
  assign SD_CS_n = !(state_q == SEND || state_q == POLL);

  always_comb begin
    SD_MOSI = 1'b1;
    if (state_q == SEND) begin
      if (bit_q < 6'd40)
        SD_MOSI = sh_q[39];
      else
        SD_MOSI = tail[3'd7 - bit_q[2:0]];
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed and random commands
// against a cycle-schedule reference model of the SPI command protocol.
module tb_sd_cmd_engine;

  localparam int RT = 8;

  logic        CLKin;
  logic        Reset;
  logic        Start;
  logic [5:0]  CmdIndex;
  logic [31:0] CmdArg;
  logic        Busy;
  logic        Done;
  logic [7:0]  Resp;
  logic        Timeout;
  logic        SD_SCLK;
  logic        SD_MOSI;
  logic        SD_MISO;
  logic        SD_CS_n;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbytes [RT];
  logic [5:0]  cur_idx;
  logic [31:0] cur_arg;
  logic [47:0] got_frame;

  sd_cmd_engine dut (
    .CLKin    (CLKin),
    .Reset    (Reset),
    .Start    (Start),
    .CmdIndex (CmdIndex),
    .CmdArg   (CmdArg),
    .Busy     (Busy),
    .Done     (Done),
    .Resp     (Resp),
    .Timeout  (Timeout),
    .SD_SCLK  (SD_SCLK),
    .SD_MOSI  (SD_MOSI),
    .SD_MISO  (SD_MISO),
    .SD_CS_n  (SD_CS_n)
  );

  initial CLKin = 1'b0;
  always #5 CLKin = ~CLKin;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as polynomial remainder of M(x)*x^7 mod (x^7+x^3+1)
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [7:0] exp_tail(input logic [5:0] idx,
                                          input logic [31:0] arg);
`ifdef SD_CRC7_EN
    return {crc7_ref({2'b01, idx, arg}), 1'b1};
`else
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return 8'h01;
`endif
  endfunction

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
    CmdIndex = idx;
    CmdArg   = arg;
    Start    = 1'b1;
    cur_idx  = idx;
    cur_arg  = arg;
  endtask

  // Called at the negedge of cycle 0 (Start high); returns at the
  // negedge of the Done cycle, or after the cycle budget expires.
  task automatic run(input string tag, input bit pulse30);
    logic [47:0] exp_frame;
    int npoll, exp_done, done_c, n, b;
    bit found;
    logic [7:0] exp_resp;
    int sclk_bad, mosi_bad, cs_bad, busy_bad;
    logic busy1, cs1;
    found = 0; npoll = RT; exp_resp = 8'hFF;
    for (int k = 0; k < RT; k++)
      if (!found && !mbytes[k][7]) begin
        found = 1; npoll = k + 1; exp_resp = mbytes[k];
      end
    exp_frame = {2'b01, cur_idx, cur_arg, exp_tail(cur_idx, cur_arg)};
    exp_done  = 113 + 16 * npoll;
    done_c = 0; sclk_bad = 0; mosi_bad = 0; cs_bad = 0; busy_bad = 0;
    busy1 = 1'b0; cs1 = 1'b1;
    got_frame = '0;
    for (int c = 1; c <= exp_done + 12; c++) begin
      @(negedge CLKin);
      if (c == 1) begin
        Start = 1'b0; busy1 = Busy; cs1 = SD_CS_n;
      end
      if (pulse30 && c == 30) begin
        Start = 1'b1; CmdIndex = ~cur_idx; CmdArg = ~cur_arg;
      end
      if (pulse30 && c == 31) Start = 1'b0;
      if (c >= 97 && c < 97 + 16 * npoll) begin
        n = (c - 97) / 16;
        b = ((c - 97) % 16) / 2;
        SD_MISO = mbytes[n][7 - b];
      end else begin
        SD_MISO = 1'b1;
      end
      if (Done) begin
        done_c = c;
        break;
      end
      if (c < exp_done) begin
        if (SD_SCLK !== 1'((c - 1) % 2)) sclk_bad++;
        if (Busy !== 1'b1) busy_bad++;
        if (SD_CS_n !== (c > 96 + 16 * npoll)) cs_bad++;
        if (c <= 96) begin
          if (SD_MOSI !== exp_frame[47 - (c - 1) / 2]) mosi_bad++;
          if (c % 2 == 1) got_frame[47 - (c - 1) / 2] = SD_MOSI;
        end else if (SD_MOSI !== 1'b1) begin
          mosi_bad++;
        end
      end
    end
    chk({tag, "_busy1"}, busy1, 1'b1);
    chk({tag, "_cs1"}, cs1, 1'b0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_mosi_b%0d", tag, k), got_frame[47 - 8 * k -: 8],
          exp_frame[47 - 8 * k -: 8]);
    chk({tag, "_sclk_bad"}, sclk_bad, 0);
    chk({tag, "_mosi_bad"}, mosi_bad, 0);
    chk({tag, "_cs_bad"}, cs_bad, 0);
    chk({tag, "_busy_bad"}, busy_bad, 0);
    chk({tag, "_done_cyc"}, done_c, exp_done);
    chk({tag, "_resp"}, Resp, exp_resp);
    chk({tag, "_tmo"}, Timeout, !found);
    chk({tag, "_busy_done"}, Busy, 1'b0);
  endtask

  task automatic set_resp(input int pos, input logic [7:0] r);
    for (int k = 0; k < RT; k++)
      mbytes[k] = (k < pos) ? (8'h80 | 8'($urandom)) : 8'hFF;
    if (pos < RT) mbytes[pos] = r;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; CmdIndex = '0; CmdArg = '0;
    SD_MISO = 1'b1;
    #2;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_resp", Resp, 8'hFF);
    chk("rst_tmo", Timeout, 1'b0);
    chk("rst_cs", SD_CS_n, 1'b1);
    chk("rst_sclk", SD_SCLK, 1'b0);
    chk("rst_mosi", SD_MOSI, 1'b1);
    @(negedge CLKin); @(negedge CLKin);
    Reset = 1'b0;
    @(negedge CLKin);

    // CMD0: 0xFF then 0x01
    for (int k = 0; k < RT; k++) mbytes[k] = 8'hFF;
    mbytes[1] = 8'h01;
    issue(6'd0, 32'd0);
    run("cmd0", 0);
    chk("cmd0_last", got_frame[7:0], 8'h95);

    // CMD8 with response in first poll byte
    @(negedge CLKin);
    set_resp(0, 8'h01);
    issue(6'd8, 32'h0000_01AA);
    run("cmd8", 0);
    chk("cmd8_last", got_frame[7:0], 8'h87);

    // timeout with MISO high, plus Start pulse while busy
    @(negedge CLKin);
    for (int k = 0; k < RT; k++) mbytes[k] = 8'hFF;
    issue(6'd17, 32'h1234_5678);
    run("tmo", 1);

    // CMD55 last byte
    @(negedge CLKin);
    set_resp(0, 8'h01);
    issue(6'd55, 32'd0);
    run("cmd55", 0);
`ifdef SD_CRC7_EN
    chk("cmd55_last", got_frame[7:0], 8'h65);
`else
    chk("cmd55_last", got_frame[7:0], 8'h01);
`endif

    // reset in the middle of SEND (cycle 50)
    @(negedge CLKin);
    issue(6'd0, 32'd0);
    for (int c = 1; c <= 49; c++) begin
      @(negedge CLKin);
      if (c == 1) Start = 1'b0;
    end
    @(posedge CLKin);
    #1 Reset = 1'b1;
    #1;
    chk("mid_rst_cs", SD_CS_n, 1'b1);
    chk("mid_rst_sclk", SD_SCLK, 1'b0);
    chk("mid_rst_mosi", SD_MOSI, 1'b1);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_done", Done, 1'b0);
    @(negedge CLKin); @(negedge CLKin);
    Reset = 1'b0;
    @(negedge CLKin);
    set_resp(1, 8'h01);
    issue(6'd0, 32'd0);
    run("post_rst", 0);

    // Start held in the Done cycle: back-to-back commands
    @(negedge CLKin);
    set_resp(0, 8'h00);
    issue(6'd0, 32'd0);
    run("chain_a", 0);
    set_resp(2, 8'h05);
    issue(6'd8, 32'h0000_01AA);
    run("chain_b", 0);

    // random commands
    for (int t = 0; t < 6; t++) begin
      @(negedge CLKin);
      set_resp(int'($urandom_range(0, RT)), 8'($urandom) & 8'h7F);
      issue(6'($urandom), $urandom);
      run($sformatf("rnd%0d", t), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

SD-card SPI command engine that consumes the divided card clock. It runs on that clock, so one SPI bit takes two clock cycles.
- Frames a 6-byte SD command (index, 32-bit argument, CRC7), shifts it out in SPI mode 0 and polls for the R1 response byte.
- Returns the response, or a timeout flag, to the SD controller FSM.
- Generates SD_SCLK, SD_MOSI and SD_CS_n toward the card pins.

## Interface
- RESP_TIMEOUT, 8: number of 0xFF poll bytes sent before declaring timeout (1..255).
- CLKin  input  1  divided SD clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  command request, sampled only in IDLE.
- CmdIndex  input  6  SD command index.
- CmdArg  input  32  command argument.
- Busy  output  1  high from acceptance until the Done cycle.
- Done  output  1  one-cycle completion pulse.
- Resp  output  8  R1 byte; 0xFF on timeout; held until the next accepted Start.
- Timeout  output  1  valid with Done; held until the next accepted Start.
- SD_SCLK  output  1  SPI clock, idles low.
- SD_MOSI  output  1  data to the card, idles high.
- SD_MISO  input  1  data from the card.
- SD_CS_n  output  1  chip select, active low.

## Operation
- States and transitions:
  - IDLE -> SEND on Start.
  - SEND -> POLL after 48 bits.
  - POLL -> TRAIL on a byte with bit7=0, or after RESP_TIMEOUT bytes.
  - TRAIL -> IDLE after 8 bits, with Done=1 on entry to IDLE.
- Command bytes, MSB first:
  - byte 0: {2'b01, CmdIndex}
  - bytes 1..4: CmdArg[31:24] down to CmdArg[7:0]
  - byte 5: {CRC7, 1'b1}
- Bit period: 2 cycles.
  - Low phase: SD_SCLK=0, MOSI driven.
  - High phase: SD_SCLK=1.
  - MISO is sampled at the edge ending the high phase.
- POLL:
  - MOSI=1; each received byte is shifted into a receive register.
  - The first byte with bit7=0 is latched into Resp; Timeout=0.
  - If all RESP_TIMEOUT bytes have bit7=1: Resp=0xFF, Timeout=1.
- SD_CS_n:
  - Low throughout SEND and POLL.
  - High in TRAIL, where 8 clocks are sent with MOSI=1.
- Start while Busy is ignored. Start in the Done cycle (IDLE) is accepted.
- Reset values, applied immediately and also on reset mid-operation:
  - SD_CS_n=1, SD_SCLK=0, SD_MOSI=1.
  - Busy=0, Done=0, Resp=0xFF, Timeout=0.
  - State=IDLE; the partial command is discarded.

## Timing
- Start high at cycle 0 in IDLE. Cycle 1: SEND, Busy=1, SD_CS_n=0.
- Bit i of the command occupies cycles 1+2i and 2+2i; SEND covers cycles 1–96.
- Poll byte n (n from 0) covers cycles 97+16n to 112+16n.
- Response in poll byte n: TRAIL covers cycles 113+16n to 128+16n; Done=1 and Busy=0 at cycle 129+16n.
- Timeout: Done at cycle 113+16·RESP_TIMEOUT.
- Resp and Timeout update in the Done cycle.

## Configuration
- With SD_CRC7_EN defined:
  - CRC7 (x^7+x^3+1, initial value 0) is computed serially over the first 40 command bits while shifting.
- Without SD_CRC7_EN:
  - byte 5 is 0x95 when CmdIndex=0, 0x87 when CmdIndex=8, and 0x01 otherwise.
  - The CRC sub-module is not instantiated.

## Structure
- Package sd_pkg holds:
  - the state enum (IDLE, SEND, POLL, TRAIL);
  - constants SD_IDLE_BYTE=8'hFF, SD_CRC_CMD0=8'h95, SD_CRC_CMD8=8'h87, SD_CRC_NONE=8'h01.
- Sub-module sd_crc7: serial CRC7 with clear, bit-enable and data-bit inputs and a 7-bit output; instantiated only under SD_CRC7_EN.

## Test plan
- CMD0, arg 0; MISO returns 0xFF then 0x01 -> MOSI bytes 40 00 00 00 00 95; Resp=0x01, Timeout=0, Done at cycle 145.
- CMD8, arg 0x000001AA; response 0x01 in poll byte 0 -> MOSI 48 00 00 01 AA 87; Done at cycle 129.
- MISO held high, RESP_TIMEOUT=8 -> Resp=0xFF, Timeout=1, Done at cycle 241; SD_CS_n high for cycles 225–240.
- CMD55, arg 0 -> last byte 0x65 with SD_CRC7_EN and 0x01 without it.
- Reset asserted at cycle 50 -> same cycle: SD_CS_n=1, SD_SCLK=0, SD_MOSI=1, Busy=0. The next CMD0 after reset completes normally.
- Start pulsed at cycle 30 -> ignored, no effect on MOSI. Start held during the Done cycle -> new command accepted, Busy=1 on the next cycle.
